// File: rtl/tsc_pkg.sv
// Shared types and defaults for the trigger-surround-cache readout.
// The window length helper keeps the derivation in one place.
package tsc_pkg;

    localparam int ADDR_W_DEF    = 5;
    localparam int DATA_W_DEF    = 8;
    localparam int PRE_TRIG_DEF  = 16;
    localparam int POST_TRIG_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        POST,
        RD_ADDR,
        RD_WAIT,
        RD_OUT,
        DONE
    } tsc_state_t;

    // Samples in the window: pre-trigger, the trigger itself, post-trigger.
    function automatic int window(input int pre, input int post);
        return pre + post + 1;
    endfunction

endpackage

// File: rtl/tsc_readout.sv
// Read-side sequencer of the trigger-surround cache: waits for the
// trigger, lets the post-trigger samples land, then streams the window.
module tsc_readout
    import tsc_pkg::*;
#(
    parameter int BUFFER_DEPTH = 32,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int PRE_TRIG     = PRE_TRIG_DEF,
    parameter int POST_TRIG    = POST_TRIG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              trig,
    input  logic [ADDR_W-1:0] trig_ptr,
    input  logic              wr_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_dat,
    output logic              out_rdy,
    input  logic              out_req,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int WIN = window(PRE_TRIG, POST_TRIG);
    // The window can never be longer than the buffer it is read from.
    localparam int WIN_USED = (WIN <= BUFFER_DEPTH) ? WIN : BUFFER_DEPTH;
    localparam int CNT_W = (POST_TRIG > 0) ? $clog2(POST_TRIG + 1) : 1;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(WIN_USED - 1);
    localparam logic [ADDR_W-1:0] PRE_OFS = ADDR_W'(PRE_TRIG);
    localparam logic [CNT_W-1:0] POST_END = CNT_W'(POST_TRIG);

    tsc_state_t        state, state_n;
    logic [ADDR_W-1:0] start_ptr, start_n;
    logic [ADDR_W-1:0] rd_idx, idx_n;
    logic [CNT_W-1:0]  post_cnt, post_n, post_inc;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] dat_n;
    logic              rdy_n, last_n;

    assign post_inc = post_cnt + 1'b1;

    // State register plus all registered outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ptr   <= '0;
            rd_idx      <= '0;
            post_cnt    <= '0;
            buf_rd_addr <= '0;
            out_dat     <= '0;
            out_rdy     <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            start_ptr   <= start_n;
            rd_idx      <= idx_n;
            post_cnt    <= post_n;
            buf_rd_addr <= addr_n;
            out_dat     <= dat_n;
            out_rdy     <= rdy_n;
            out_last    <= last_n;
            busy        <= (state_n != IDLE);
            done        <= (state_n == DONE);
        end
    end

    // Next-state and next-register values for the sequencer.
    always_comb begin
        state_n = state;
        start_n = start_ptr;
        idx_n   = rd_idx;
        post_n  = post_cnt;
        addr_n  = buf_rd_addr;
        dat_n   = out_dat;
        rdy_n   = out_rdy;
        last_n  = out_last;
        unique case (state)
            IDLE: begin
                if (arm) state_n = ARMED;
            end
            ARMED: begin
                if (trig) begin
                    start_n = trig_ptr - PRE_OFS;
                    idx_n   = '0;
                    post_n  = '0;
                    state_n = (POST_TRIG == 0) ? RD_ADDR : POST;
                end
            end
            POST: begin
                if (wr_en) begin
                    post_n = post_inc;
                    if (post_inc == POST_END) state_n = RD_ADDR;
                end
            end
            RD_ADDR: begin
                addr_n  = start_ptr + rd_idx;
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                dat_n   = buf_rd_dat;
                rdy_n   = 1'b1;
                last_n  = (rd_idx == IDX_LAST);
                state_n = RD_OUT;
            end
            RD_OUT: begin
                if (out_req) begin
                    rdy_n   = 1'b0;
                    last_n  = 1'b0;
                    idx_n   = rd_idx + 1'b1;
                    state_n = out_last ? DONE : RD_ADDR;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tsc_readout.sv
// Randomized bench for tsc_readout: a behavioural buffer plus a window
// model computed from trigger pointer arithmetic.
module tb_tsc_readout;

    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int PRE = 16;
    localparam int WIN = 32;
    localparam int WIN0 = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          trig = 1'b0;
    logic [AW-1:0] trig_ptr = '0;
    logic          wr_en = 1'b0;
    logic          out_req = 1'b0;

    logic [AW-1:0] buf_rd_addr, addr0;
    logic [DW-1:0] buf_rd_dat, dat_in0;
    logic          out_rdy, out_last, busy, done;
    logic [DW-1:0] out_dat;
    logic          rdy0, last0, busy0, done0;
    logic [DW-1:0] dat0;

    logic [DW-1:0] mem [32];
    int            n_chk = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    bit            sel = 1'b0;
    logic [DW-1:0] exp_q [$];

    logic          r_rdy, r_last, r_done;
    logic [DW-1:0] r_dat;

    always #5 clk = ~clk;

    assign buf_rd_dat = mem[buf_rd_addr];
    assign dat_in0    = mem[addr0];

    tsc_readout dut (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig),
        .trig_ptr(trig_ptr), .wr_en(wr_en),
        .buf_rd_addr(buf_rd_addr), .buf_rd_dat(buf_rd_dat),
        .out_rdy(out_rdy), .out_req(out_req), .out_dat(out_dat),
        .out_last(out_last), .busy(busy), .done(done)
    );

    tsc_readout #(.POST_TRIG(0)) dut0 (
        .clk(clk), .rst(rst), .arm(arm), .trig(trig),
        .trig_ptr(trig_ptr), .wr_en(wr_en),
        .buf_rd_addr(addr0), .buf_rd_dat(dat_in0),
        .out_rdy(rdy0), .out_req(out_req), .out_dat(dat0),
        .out_last(last0), .busy(busy0), .done(done0)
    );

    always_comb begin
        r_rdy  = sel ? rdy0  : out_rdy;
        r_dat  = sel ? dat0  : out_dat;
        r_last = sel ? last0 : out_last;
        r_done = sel ? done0 : done;
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_req = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Window model: n consecutive buffer words starting PRE before trigger.
    task automatic build_exp(input int tp, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++)
            exp_q.push_back(mem[(tp - PRE + i + 64) % 32]);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
    endtask

    // Arm, trigger (with a same-cycle write), then nwr qualified writes.
    task automatic capture(input int tp, input int nwr, input bit noise);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("armed_busy", busy, 1);
        trig = 1'b1;
        trig_ptr = AW'(tp);
        wr_en = 1'b1;
        step();
        trig = 1'b0;
        wr_en = 1'b0;
        for (int k = 0; k < nwr; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                if (noise) begin
                    trig = 1'b1;
                    trig_ptr = AW'($urandom);
                    arm = 1'b1;
                end
                step();
                trig = 1'b0;
                arm = 1'b0;
            end
            if (k == nwr - 1) chk("post_no_rdy", out_rdy, 0);
            wr_en = 1'b1;
            step();
            wr_en = 1'b0;
        end
    endtask

    // Drain a window; stall the host on one sample or reset mid-stream.
    task automatic read_window(input int n, input int stall_at,
                               input int stall_len, input int abort_at,
                               output int first);
        int idx, cyc, stalled;
        bit fin, aborted;
        logic [DW-1:0] held;
        idx = 0; cyc = 0; stalled = 0; fin = 0; aborted = 0;
        first = -1;
        held = '0;
        while (!fin && cyc < 600) begin
            if (r_rdy && first < 0) first = cyc;
            if (r_rdy && idx == abort_at) begin
                out_req = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("abort_rdy", out_rdy, 0);
                chk("abort_busy", busy, 0);
                aborted = 1;
                fin = 1;
            end else begin
                if (r_rdy && idx == stall_at && stalled < stall_len) begin
                    if (stalled == 0) held = r_dat;
                    else chk("stall_dat", r_dat, held);
                    out_req = 1'b0;
                    stalled++;
                end else begin
                    out_req = 1'b1;
                end
                if (r_rdy && out_req) begin
                    chk("dat", r_dat, exp_q[idx]);
                    chk("last", r_last, idx == n - 1);
                    idx++;
                end
                step();
                cyc++;
                if (idx == n) begin
                    chk("done", r_done, 1);
                    fin = 1;
                end
            end
        end
        out_req = 1'b0;
        if (!aborted) begin
            chk("count", idx, n);
            step();
            chk("done_end", r_done, 0);
        end
    endtask

    initial begin
        int first, tp, dc;
        do_reset();
        chk("rst_rdy", out_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dat", out_dat, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr", buf_rd_addr, 0);

        for (int i = 0; i < 32; i++) mem[i] = DW'(i);
        capture(20, 15, 0);
        build_exp(20, WIN);
        chk("basic_first", exp_q[0], 4);
        read_window(WIN, -1, 0, -1, first);
        chk("latency", first, 2);
        chk("idle_busy", busy, 0);

        do_reset();
        fill_rand();
        capture(3, 15, 0);
        build_exp(3, WIN);
        chk("wrap_first", exp_q[0], mem[19]);
        read_window(WIN, -1, 0, -1, first);

        do_reset();
        fill_rand();
        tp = $urandom_range(0, 31);
        capture(tp, 15, 0);
        build_exp(tp, WIN);
        read_window(WIN, 7, 6, -1, first);

        do_reset();
        trig = 1'b1;
        trig_ptr = 5'd9;
        step();
        trig = 1'b0;
        chk("idle_trig_busy", busy, 0);
        step();
        chk("idle_trig_busy2", busy, 0);
        fill_rand();
        tp = $urandom_range(0, 31);
        capture(tp, 15, 1);
        build_exp(tp, WIN);
        read_window(WIN, -1, 0, -1, first);
        chk("gated_latency", first, 2);

        do_reset();
        fill_rand();
        dc = done_cnt;
        capture(11, 15, 0);
        build_exp(11, WIN);
        read_window(WIN, -1, 0, 10, first);
        step();
        step();
        chk("abort_done", done_cnt, dc);
        capture(25, 15, 0);
        build_exp(25, WIN);
        read_window(WIN, -1, 0, -1, first);
        chk("after_abort_done", done_cnt, dc + 1);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            fill_rand();
            tp = $urandom_range(0, 31);
            capture(tp, 15, r[0]);
            build_exp(tp, WIN);
            read_window(WIN, $urandom_range(0, 31),
                        $urandom_range(1, 4), -1, first);
        end

        do_reset();
        fill_rand();
        sel = 1'b1;
        tp = $urandom_range(0, 31);
        arm = 1'b1;
        step();
        arm = 1'b0;
        trig = 1'b1;
        trig_ptr = AW'(tp);
        step();
        trig = 1'b0;
        first = 1;
        while (!rdy0 && first < 20) begin
            step();
            first++;
        end
        chk("p0_latency", first, 3);
        build_exp(tp, WIN0);
        read_window(WIN0, -1, 0, -1, first);
        chk("p0_idle", busy0, 0);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
